// File: rtl/argmax_seq_ctrl_if.sv
// Handshake bundle between the argmax sequencer and its neighbours: the
// score stream, the comparator tap, the result channel and run control.
interface argmax_seq_ctrl_if #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 16,
  parameter int IMG_CNT_W = 16
);
  logic                          start;
  logic [IMG_CNT_W-1:0]          num_img;
  logic                          score_valid;
  logic [DATA_W-1:0]             score_data;
  logic                          score_ready;
  logic [NUM_CLASS*DATA_W-1:0]   cmp_data;
  logic [31:0]                   cmp_result;
  logic                          res_valid;
  logic [31:0]                   res_data;
  logic [IMG_CNT_W-1:0]          res_idx;
  logic                          res_ready;
  logic                          busy;
  logic                          done;

  modport slave (
    input  start, num_img, score_valid, score_data, cmp_result, res_ready,
    output score_ready, cmp_data, res_valid, res_data, res_idx, busy, done
  );

  modport master (
    output start, num_img, score_valid, score_data, cmp_result, res_ready,
    input  score_ready, cmp_data, res_valid, res_data, res_idx, busy, done
  );
endinterface

// File: rtl/argmax_seq_ctrl.sv
// Sequencer that packs streamed class scores into the argmax comparator
// input, captures the winning class and returns it over valid/ready.
module argmax_seq_ctrl #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 16,
  parameter int IMG_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  argmax_seq_ctrl_if.slave   bus
);

  localparam int CMP_W  = NUM_CLASS * DATA_W;
  localparam int BEAT_W = $clog2(NUM_CLASS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CLASS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EVAL = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_q,     state_d;
  logic [IMG_CNT_W-1:0]  num_img_q,   num_img_d;
  logic [IMG_CNT_W-1:0]  img_cnt_q,   img_cnt_d;
  logic [BEAT_W-1:0]     beat_q,      beat_d;
  logic [CMP_W-1:0]      cmp_data_q,  cmp_data_d;
  logic                  res_valid_q, res_valid_d;
  logic [31:0]           res_data_q,  res_data_d;
  logic [IMG_CNT_W-1:0]  res_idx_q,   res_idx_d;

  // Beat b carries class b+1 and lands in slot b (class 1 in the low bits).
  function automatic logic [CMP_W-1:0] put_slot(
    input logic [CMP_W-1:0]  vec,
    input logic [BEAT_W-1:0] beat,
    input logic [DATA_W-1:0] score
  );
    logic [CMP_W-1:0] r;
    r = vec;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (beat == BEAT_W'(i)) begin
        r[i*DATA_W +: DATA_W] = score;
      end
    end
    return r;
  endfunction

  function automatic logic is_last_img(
    input logic [IMG_CNT_W-1:0] cnt,
    input logic [IMG_CNT_W-1:0] total
  );
    return cnt == (total - IMG_CNT_W'(1));
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      num_img_q   <= '0;
      img_cnt_q   <= '0;
      beat_q      <= '0;
      cmp_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      num_img_q   <= num_img_d;
      img_cnt_q   <= img_cnt_d;
      beat_q      <= beat_d;
      cmp_data_q  <= cmp_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_img_d   = num_img_q;
    img_cnt_d   = img_cnt_q;
    beat_d      = beat_q;
    cmp_data_d  = cmp_data_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_img != '0) begin
            num_img_d  = bus.num_img;
            img_cnt_d  = '0;
            beat_d     = '0;
            cmp_data_d = '0;
            state_d    = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end

      LOAD: begin
        if (bus.score_valid) begin
          cmp_data_d = put_slot(cmp_data_q, beat_q, bus.score_data);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = EVAL;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      // cmp_data has been stable for a full cycle, so the comparator has settled.
      EVAL: begin
        res_data_d  = bus.cmp_result;
        res_idx_d   = img_cnt_q;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end

      OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (is_last_img(img_cnt_q, num_img_q)) begin
            state_d = DONE;
          end else begin
            img_cnt_d = img_cnt_q + IMG_CNT_W'(1);
            state_d   = LOAD;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.score_ready = (state_q == LOAD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.cmp_data    = cmp_data_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_idx     = res_idx_q;

endmodule

// File: doc/argmax_seq_ctrl.md
# argmax_seq_ctrl

Sequencer for the 10-class argmax comparator at the output of the one-layer classifier. Accepts class scores streamed one per cycle from the fully-connected layer and packs them into the comparator's 160-bit input. It captures the combinational class index the comparator returns and hands it to the result writer over a valid/ready handshake. Runs a programmed number of images per `start`, then pulses `done`.

## Interface
- `NUM_CLASS`, 10: classes per image. Fixed by the comparator; any other value is unsupported.
- `DATA_W`, 16: score width, unsigned.
- `IMG_CNT_W`, 16: width of the image count and image index.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a run. Honoured only in IDLE.
- `num_img` in IMG_CNT_W: images in the run, latched on an accepted `start`.
- `score_valid` in 1: score beat valid.
- `score_data` in DATA_W: score beat.
- `score_ready` out 1: beat accepted when `score_valid & score_ready`.
- `cmp_data` out 160: packed scores driven to the comparator input.
- `cmp_result` in 32: comparator output. 1..10 = winning class; 0 = none.
- `res_valid` out 1: result available.
- `res_data` out 32: captured class index.
- `res_idx` out IMG_CNT_W: 0-based image number of the result.
- `res_ready` in 1: result consumed when `res_valid & res_ready`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of run.

## Operation
- States: IDLE, LOAD, EVAL, OUT, DONE.
- **IDLE**
  - `score_ready`=0.
  - `start` with `num_img`≠0: latch `num_img`, clear the image counter, beat counter and `cmp_data`, then go to LOAD.
  - `start` with `num_img`=0: go to DONE.
- **LOAD**
  - `score_ready`=1.
  - Beat counter b runs 0..9. Beat b is class b+1 and is written to `cmp_data[16(b+1)-1 : 16b]`. Class 1 goes to [15:0]; class 10 goes to [159:144].
  - Gaps in `score_valid` are allowed; the counter advances only on an accepted beat.
  - Accepting beat 9 moves to EVAL and resets the beat counter.
- **EVAL**
  - `score_ready`=0; `cmp_data` is stable with all 10 slots.
  - Register `res_data`←`cmp_result` and `res_idx`←image counter, set `res_valid`=1, then go to OUT.
- **OUT**
  - `res_valid` is held, and `res_data`/`res_idx` stay stable, until `res_ready`.
  - On handshake: clear `res_valid`.
  - If image counter = latched `num_img`−1, go to DONE; otherwise increment the counter and go to LOAD.
  - Slots are overwritten by the next image. `cmp_data` is not cleared between images.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- Comparison semantics are owned by the comparator and pass through unchanged:
  - compare is unsigned;
  - on a tie the highest class index wins.
- `score_valid` outside LOAD is ignored; no beat is consumed.
- `start` outside IDLE is ignored; `num_img` is not re-latched.
- Reset (`rst`=0), at any time:
  - state→IDLE;
  - all outputs, counters and `cmp_data` → 0;
  - a partial image or pending result is discarded.
- Reset values of every output: `score_ready`=0, `cmp_data`=0, `res_valid`=0, `res_data`=0, `res_idx`=0, `busy`=0, `done`=0.

## Timing
- `start` accepted in cycle S: LOAD from S+1, so `score_ready` is high in S+1.
- Last beat accepted in cycle T: EVAL in T+1, `res_valid` rises in T+2.
- Minimum per-image period with no stalls is 12 cycles: 10 LOAD, 1 EVAL, 1 OUT.
- Final handshake in cycle H: `done` high in H+1, `busy` low from H+2.
- `num_img`=0 with `start` in S: `done` high in S+1, with no `res_valid`.
- `busy` rises in S+1 and stays high through the DONE cycle.
- `cmp_data` is registered. `cmp_result` is combinational from it and is sampled only in EVAL.

## Test plan
- **Single image**: `num_img`=1, scores for classes 1..10 = 0x0001..0x000A, no stalls. Expect:
  - `res_valid` 2 cycles after the 10th beat, with `res_data`=10 and `res_idx`=0;
  - `done` one cycle after the handshake;
  - `cmp_data`=0x000A_0009_..._0001.
- **Ties and unsigned compare**, three images:
  - all scores 0x0005 → `res_data`=10;
  - class 3 = class 7 = 0x8000, rest 0x7FFF → 7;
  - class 1 = 0xFFFF, rest 0 → 1.
- **Backpressure**: hold `res_ready`=0 for 5 cycles. Expect:
  - `res_valid`, `res_data` and `res_idx` stable throughout;
  - `score_ready`=0 throughout;
  - the next image loads only after the handshake.
- **Multi-image with gaps**: `num_img`=3, `score_valid` toggling every other cycle. Expect:
  - three results with `res_idx` 0,1,2 and the correct classes;
  - exactly one `done` pulse;
  - a `start` pulsed mid-run is ignored.
- **Zero-length run**: `num_img`=0 → `done` in S+1, `res_valid` never asserted, back in IDLE at S+2.
- **Reset mid-operation**: `rst` low after 4 beats. Expect all outputs 0 immediately; a fresh `num_img`=1 run afterwards yields the correct class.
